pc_unit: RTL and testbench

Fetch-stage program counter for the five-stage MIPS pipeline. It holds the PC register and picks the next fetch address from sequential flow, branch/jump redirects, exception entry and `eret`. It is a direct consumer of the immediate extender: branch targets use the extender's sign-extended, two-bit-left-shifted offset as-is. It drives the instruction-memory address and the F-stage exception flags that travel down the pipeline with the fetched instruction.

---
 rtl/pc_unit.sv | 102 ++++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter for the five-stage MIPS pipeline.
// Holds the PC register, selects the next fetch address (sequential,
// branch/jump redirect, exception entry, eret) and produces the F-stage
// exception flags that travel down the pipe with the fetched instruction.
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] d_pc,
  input  logic [31:0] ext_imm,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] f_pc,
  output logic        f_adel,
  output logic        f_bd,
  output logic [31:0] d_link
);

  // Control-transfer encodings from the D-stage decoder; 4-7 fall back to SEQ.
  typedef enum logic [2:0] {
    NPC_SEQ    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JREG   = 3'd3
  } npc_op_e;

  logic [31:0] pc_q, pc_d;
  logic        redir_exc_q, redir_exc_d;

  logic [31:0] d_pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] seq_pc;
  logic        is_xfer;

  // Redirect targets, computed from the D-stage operands every cycle.
  always_comb begin
    d_pc_plus4 = d_pc + 32'd4;
    br_target  = d_pc_plus4 + ext_imm;
    j_target   = {d_pc_plus4[31:28], instr_index, 2'b00};
    seq_pc     = pc_q + 32'd4;
    is_xfer    = (npc_op == NPC_BRANCH) || (npc_op == NPC_JUMP) ||
                 (npc_op == NPC_JREG);
  end

  // Next-PC priority select: req > eret > stall > redirect > sequential.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pc_d        = seq_pc;
    redir_exc_d = 1'b0;
    if (req) begin
      pc_d        = HANDLER_PC;
      redir_exc_d = 1'b1;
    end else if (eret) begin
      // eret has no delay slot, so it does not wait out a stall.
      pc_d        = epc;
      redir_exc_d = 1'b1;
    end else if (stall) begin
      pc_d        = pc_q;
      redir_exc_d = redir_exc_q;
    end else begin
      unique case (npc_op)
        NPC_BRANCH: pc_d = br_taken ? br_target : seq_pc;
        NPC_JUMP:   pc_d = j_target;
        NPC_JREG:   pc_d = rs_data;  // misalignment is flagged via f_adel, not fixed
        default:    pc_d = seq_pc;
      endcase
    end
  end

  // PC and exception-redirect flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      pc_q        <= RESET_PC;
      redir_exc_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      redir_exc_q <= redir_exc_d;
    end
  end

  // F-stage outputs derived from the PC register and D-stage control.
  always_comb begin
    f_pc   = pc_q;
    f_adel = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
    // The instruction fetched right after an exception/eret redirect is never a delay slot.
    f_bd   = is_xfer && !redir_exc_q;
    d_link = d_pc + 32'd8;
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized stimulus for pc_unit,
// checked against a behavioural next-PC model kept in the bench.
module tb_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, req, eret;
  logic [2:0]  npc_op;
  logic [31:0] d_pc, ext_imm, rs_data, epc;
  logic [25:0] instr_index;
  logic [31:0] f_pc, d_link;
  logic        f_adel, f_bd;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the PC and the "loaded by req/eret" flag should be.
  logic [31:0] m_pc;
  logic        m_redir;

  always #5 clk = ~clk;

  pc_unit #(
    .RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC),
    .TEXT_LO(TEXT_LO), .TEXT_HI(TEXT_HI)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op),
    .br_taken(br_taken), .d_pc(d_pc), .ext_imm(ext_imm),
    .instr_index(instr_index), .rs_data(rs_data), .req(req), .eret(eret),
    .epc(epc), .f_pc(f_pc), .f_adel(f_adel), .f_bd(f_bd), .d_link(d_link)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < TEXT_LO) || (pc > TEXT_HI);
  endfunction

  task automatic drive(input logic rst, input logic stl, input logic [2:0] op,
                       input logic tkn, input logic rq, input logic er);
    reset = rst; stall = stl; npc_op = op; br_taken = tkn; req = rq; eret = er;
  endtask

  // Check all outputs against the model, then advance one clock and the model.
  task automatic tick(input string tag);
    logic [31:0] nxt;
    logic        nredir;
    #1;
    check({tag, ".f_pc"},   f_pc, m_pc);
    check({tag, ".f_adel"}, {31'd0, f_adel}, {31'd0, ref_adel(m_pc)});
    check({tag, ".f_bd"},   {31'd0, f_bd},
          {31'd0, (npc_op >= 3'd1 && npc_op <= 3'd3 && !m_redir)});
    check({tag, ".d_link"}, d_link, d_pc + 32'd8);
    nxt = m_pc + 4; nredir = 1'b0;
    if (reset)      begin nxt = RESET_PC;   nredir = 1'b0; end
    else if (req)   begin nxt = HANDLER_PC; nredir = 1'b1; end
    else if (eret)  begin nxt = epc;        nredir = 1'b1; end
    else if (stall) begin nxt = m_pc;       nredir = m_redir; end
    else if (npc_op == 3'd1 && br_taken) nxt = d_pc + 4 + ext_imm;
    else if (npc_op == 3'd2) nxt = ((d_pc + 4) & 32'hF000_0000) + instr_index * 4;
    else if (npc_op == 3'd3) nxt = rs_data;
    @(posedge clk);
    #1;
    m_pc = nxt; m_redir = nredir;
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    d_pc = 32'h0000_3000; ext_imm = '0; instr_index = '0; rs_data = '0; epc = '0;

    // Reset state on the first reset edge.
    @(posedge clk); #1;
    m_pc = RESET_PC; m_redir = 1'b0;
    check("rst.f_pc", f_pc, 32'h0000_3000);
    check("rst.f_adel", {31'd0, f_adel}, 32'd0);
    check("rst.f_bd", {31'd0, f_bd}, 32'd0);
    check("rst.d_link", d_link, 32'h0000_3008);

    // Free-running sequential fetch.
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick("seq0"); tick("seq1"); tick("seq2");
    check("seq.f_pc", f_pc, 32'h0000_300C);

    // Taken branch: 0x3010 + 4 - 8.
    d_pc = 32'h0000_3010; ext_imm = 32'hFFFF_FFF8;
    drive(1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    #1 check("br_t.bd", {31'd0, f_bd}, 32'd1);
    tick("br_t");
    check("br_t.f_pc", f_pc, 32'h0000_300C);
    // Untaken branch still marks a delay slot.
    drive(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    #1 check("br_nt.bd", {31'd0, f_bd}, 32'd1);
    tick("br_nt");
    check("br_nt.f_pc", f_pc, 32'h0000_3010);

    // J from 0x3020 with index 0xC40.
    d_pc = 32'h0000_3020; instr_index = 26'h0000C40;
    drive(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick("j");
    check("j.f_pc", f_pc, 32'h0000_3100);
    // JR to a misaligned address.
    rs_data = 32'h0000_3002;
    drive(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tick("jr");
    check("jr.f_pc", f_pc, 32'h0000_3002);
    check("jr.adel", {31'd0, f_adel}, 32'd1);

    // Stall three cycles with J in D, then release.
    drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    tick("stl0"); tick("stl1"); tick("stl2");
    check("stl.hold", f_pc, 32'h0000_3002);
    drive(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    tick("stl_rel");
    check("stl_rel.f_pc", f_pc, 32'h0000_3100);

    // req + eret + stall together: req wins, following fetch is not a delay slot.
    epc = 32'h0000_3040;
    drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
    tick("req");
    check("req.f_pc", f_pc, 32'h0000_4180);
    drive(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    #1 check("req.bd", {31'd0, f_bd}, 32'd0);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick("eret");
    check("eret.f_pc", f_pc, 32'h0000_3040);

    // Reset mid-stream with a stalled branch in D.
    drive(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    tick("rst_mid");
    check("rst_mid.f_pc", f_pc, 32'h0000_3000);

    // Walk off the top of the text segment.
    rs_data = TEXT_HI;
    drive(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tick("hi_jr");
    check("hi.adel", {31'd0, f_adel}, 32'd0);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick("hi_seq");
    check("hi_seq.f_pc", f_pc, 32'h0000_7000);
    check("hi_seq.adel", {31'd0, f_adel}, 32'd1);

    // 32-bit wrap of the PC.
    rs_data = 32'hFFFF_FFFC;
    drive(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tick("wrap_jr");
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick("wrap_seq");
    check("wrap.f_pc", f_pc, 32'h0000_0000);
    check("wrap.adel", {31'd0, f_adel}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      d_pc        = TEXT_LO + 4 * $urandom_range(0, 4095);
      ext_imm     = {{14{$urandom_range(0, 1) == 1}}, 16'($urandom), 2'b00};
      instr_index = 26'($urandom);
      rs_data     = ($urandom_range(0, 7) == 0) ? $urandom : TEXT_LO + 4 * $urandom_range(0, 4095);
      epc         = ($urandom_range(0, 7) == 0) ? $urandom : TEXT_LO + 4 * $urandom_range(0, 4095);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, 3'($urandom),
            1'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
